// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The stall statistics counter is enabled by defining HAZARD_STATS_EN.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  localparam int MDU_TIMEOUT = 64;
  localparam int STAT_W      = 16;
  // Watchdog wide enough to hold MDU_TIMEOUT itself.
  localparam int WD_W        = $clog2(MDU_TIMEOUT + 1);

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for stall statistics.
// Only instantiated when HAZARD_STATS_EN is defined.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: load-use, redirect and mul/div wait.
// Defining HAZARD_STATS_EN adds a saturating stall-cycle counter on stall_cycles.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic [4:0]        ex_rt,
  input  logic              ex_memread,
  input  logic              ex_redirect,
  input  logic              mdu_start,
  input  logic              mdu_done,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              mdu_busy,
  output logic              mdu_timeout,
  output logic [STAT_W-1:0] stall_cycles
);

  state_t          state, state_next;
  logic [WD_W-1:0] wd;
  logic            wd_clr, wd_inc, to_set;
  logic            load_use;

  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    state_next  = state;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    wd_clr      = 1'b0;
    wd_inc      = 1'b0;
    to_set      = 1'b0;
    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
          end else if (mdu_start) begin
            state_next = MDU_WAIT;
            wd_clr     = 1'b1;
          end
        end
        MDU_WAIT: begin
          if (mdu_done) begin
            state_next = RUN;
          end else begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            wd_inc      = 1'b1;
            // This cycle is the last one the watchdog allows.
            if (wd == WD_W'(MDU_TIMEOUT - 1)) begin
              to_set     = 1'b1;
              state_next = RUN;
            end
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wd          <= '0;
      mdu_timeout <= 1'b0;
    end else begin
      state <= state_next;
      if (wd_clr) begin
        wd <= '0;
      end else if (wd_inc) begin
        wd <= wd + 1'b1;
      end
      if (to_set) begin
        mdu_timeout <= 1'b1;
      end
    end
  end

  assign mdu_busy = (state == MDU_WAIT);

`ifdef HAZARD_STATS_EN
  sat_counter #(.W(STAT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~pc_we),
    .count (stall_cycles)
  );
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// against a cycle-level behavioural model. Honours HAZARD_STATS_EN for stall_cycles.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        id_uses_rt = 1'b0, ex_memread = 1'b0, ex_redirect = 1'b0;
  logic        mdu_start = 1'b0, mdu_done = 1'b0;
  logic        pc_we, ifid_we, ifid_flush, idex_bubble, mdu_busy, mdu_timeout;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: waiting flag, cycles already spent waiting, sticky timeout, stall total.
  bit m_wait, m_to;
  int m_waited, m_stalls;
  bit nx_wait, nx_to;
  int nx_waited;
  logic [5:0] exp_vec;  // {pc_we, ifid_we, ifid_flush, idex_bubble, mdu_busy, mdu_timeout}

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rt(ex_rt), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .pc_we(pc_we), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .mdu_busy(mdu_busy),
    .mdu_timeout(mdu_timeout), .stall_cycles(stall_cycles)
  );

  function automatic logic [5:0] dut_vec();
    return {pc_we, ifid_we, ifid_flush, idex_bubble, mdu_busy, mdu_timeout};
  endfunction

  task automatic model_reset();
    m_wait = 0; m_to = 0; m_waited = 0; m_stalls = 0;
  endtask

  // Expected outputs for the current cycle and the model state after the next edge.
  task automatic model_eval();
    bit hazard;
    bit pc, fw, fl, bb;
    nx_wait = m_wait; nx_to = m_to; nx_waited = m_waited;
    pc = 1; fw = 1; fl = 0; bb = 0;
    if (m_wait) begin
      if (mdu_done) begin
        nx_wait = 0;
      end else begin
        pc = 0; fw = 0; bb = 1;
        if (m_waited + 1 >= TIMEOUT) begin
          nx_wait = 0; nx_to = 1;
        end else begin
          nx_waited = m_waited + 1;
        end
      end
    end else begin
      hazard = ex_memread && (ex_rt != 0) &&
               ((ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
      if (ex_redirect) begin
        fl = 1; bb = 1;
      end else if (hazard) begin
        pc = 0; fw = 0; bb = 1;
      end else if (mdu_start) begin
        nx_wait = 1; nx_waited = 0;
      end
    end
    exp_vec = {pc, fw, fl, bb, m_wait, m_to};
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic [4:0] ert, input logic mr, input logic redir,
                       input logic ms, input logic md);
    @(negedge clk);
    id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_rt = ert;
    ex_memread = mr; ex_redirect = redir; mdu_start = ms; mdu_done = md;
    #1;
    model_eval();
  endtask

  task automatic commit();
    @(posedge clk);
    if (STATS && !exp_vec[5] && m_stalls < 16'hFFFF) m_stalls++;
    m_wait = nx_wait; m_to = nx_to; m_waited = nx_waited;
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; id_uses_rt = 0; ex_rt = '0;
    ex_memread = 0; ex_redirect = 0; mdu_start = 0; mdu_done = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #1;
    n_checks++;
    if (dut_vec() !== 6'b001100) begin
      $display("FAIL reset_outputs: got %b want %b", dut_vec(), 6'b001100); n_fail++;
    end
    n_checks++;
    if (stall_cycles !== 16'd0) begin
      $display("FAIL reset_stalls: got %0d want 0", stall_cycles); n_fail++;
    end
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_load_use();
    drive(5'd5, 5'd0, 0, 5'd5, 1, 0, 0, 0);
    n_checks++;
    if (dut_vec() !== exp_vec || exp_vec[5:2] !== 4'b0001) begin
      $display("FAIL load_use_stall: got %b want %b", dut_vec(), exp_vec); n_fail++;
    end
    commit();
    drive(5'd5, 5'd0, 0, 5'd5, 0, 0, 0, 0);
    n_checks++;
    if (dut_vec() !== exp_vec || pc_we !== 1'b1) begin
      $display("FAIL load_use_release: got %b want %b", dut_vec(), exp_vec); n_fail++;
    end
    commit();
    drive(5'd1, 5'd9, 1, 5'd9, 1, 0, 0, 0);
    n_checks++;
    if (dut_vec() !== exp_vec || pc_we !== 1'b0) begin
      $display("FAIL load_use_rt: got %b want %b", dut_vec(), exp_vec); n_fail++;
    end
    commit();
    drive(5'd1, 5'd9, 0, 5'd9, 1, 0, 0, 0);
    n_checks++;
    if (dut_vec() !== exp_vec || pc_we !== 1'b1) begin
      $display("FAIL load_use_rt_unused: got %b want %b", dut_vec(), exp_vec); n_fail++;
    end
    commit();
  endtask

  task automatic test_zero_reg();
    drive(5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0);
    n_checks++;
    if (dut_vec() !== exp_vec || pc_we !== 1'b1 || idex_bubble !== 1'b0) begin
      $display("FAIL zero_reg_no_stall: got %b want %b", dut_vec(), exp_vec); n_fail++;
    end
    commit();
  endtask

  task automatic test_redirect_priority();
    drive(5'd7, 5'd0, 0, 5'd7, 1, 1, 1, 0);
    n_checks++;
    if (dut_vec() !== exp_vec || exp_vec[5:2] !== 4'b1111) begin
      $display("FAIL redirect_priority: got %b want %b", dut_vec(), exp_vec); n_fail++;
    end
    commit();
    drive(5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    n_checks++;
    if (mdu_busy !== 1'b0) begin
      $display("FAIL redirect_drops_mdu: got busy=%b want 0", mdu_busy); n_fail++;
    end
    commit();
  endtask

  // Start, then nine waiting cycles, with mdu_done raised on the tenth waiting cycle.
  task automatic test_mdu_done();
    int busy_seen = 0;
    int base = stall_cycles;
    int mbase = m_stalls;
    drive(5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1);
    n_checks++;
    if (dut_vec() !== exp_vec) begin
      $display("FAIL mdu_start_cycle: got %b want %b", dut_vec(), exp_vec); n_fail++;
    end
    commit();
    for (int i = 0; i < 10; i++) begin
      drive(5'd3, 5'd0, 0, 5'd3, 1, (i == 4), 0, (i == 9));
      if (mdu_busy === 1'b1) busy_seen++;
      n_checks++;
      if (dut_vec() !== exp_vec) begin
        $display("FAIL mdu_wait_cycle%0d: got %b want %b", i, dut_vec(), exp_vec); n_fail++;
      end
      commit();
    end
    drive(5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    n_checks++;
    if (busy_seen != 10 || mdu_busy !== 1'b0) begin
      $display("FAIL mdu_busy_len: got %0d busy=%b want 10 busy=0", busy_seen, mdu_busy);
      n_fail++;
    end
    n_checks++;
    if (int'(stall_cycles) - base != m_stalls - mbase) begin
      $display("FAIL mdu_stall_count: got %0d want %0d", int'(stall_cycles) - base,
               m_stalls - mbase);
      n_fail++;
    end
    commit();
  endtask

  task automatic test_timeout();
    drive(5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
    commit();
    for (int i = 0; i < TIMEOUT; i++) begin
      drive(5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
      n_checks++;
      if (dut_vec() !== exp_vec || mdu_busy !== 1'b1) begin
        $display("FAIL timeout_wait%0d: got %b want %b", i, dut_vec(), exp_vec); n_fail++;
      end
      commit();
    end
    drive(5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    n_checks++;
    if (dut_vec() !== exp_vec || mdu_timeout !== 1'b1 || mdu_busy !== 1'b0) begin
      $display("FAIL timeout_flag: got %b want %b", dut_vec(), exp_vec); n_fail++;
    end
    commit();
  endtask

  task automatic test_reset_mid_wait();
    drive(5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
    commit();
    for (int i = 0; i < 5; i++) begin
      drive(5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
      commit();
    end
    @(negedge clk);
    rst = 1;
    #1;
    n_checks++;
    if (dut_vec() !== 6'b001100 || stall_cycles !== 16'd0) begin
      $display("FAIL reset_mid_wait: got %b/%0d want 001100/0", dut_vec(), stall_cycles);
      n_fail++;
    end
    model_reset();
    @(negedge clk);
    rst = 0;
    drive(5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    n_checks++;
    if (dut_vec() !== exp_vec || dut_vec() !== 6'b110000) begin
      $display("FAIL reset_release_run: got %b want %b", dut_vec(), exp_vec); n_fail++;
    end
    commit();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
            5'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 19) == 0));
      n_checks++;
      if (dut_vec() !== exp_vec) begin
        $display("FAIL random_cycle%0d: got %b want %b", i, dut_vec(), exp_vec); n_fail++;
      end
      n_checks++;
      if (int'(stall_cycles) != m_stalls) begin
        $display("FAIL random_stalls%0d: got %0d want %0d", i, stall_cycles, m_stalls);
        n_fail++;
      end
      commit();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_redirect_priority();
    test_mdu_done();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
